// File: rtl/gpio_serial_cfg_bank.sv
// gpio_serial_cfg_bank
//
// A bank of NUM_REGS serially loaded configuration registers fed from PS GPIO
// lines. All registers share one serial data line. Each register has its own
// serial clock, and one commit line is common to the bank. Every register has
// a shadow stage that collects bits and an active stage that drives the
// DAC/ADC control logic. On commit, a shadow moves to its active stage only if
// exactly REG_WIDTH bits were shifted in since the previous commit. No bits
// leaves the register untouched. Any other count raises a sticky framing error.
//
// Optional feature macro: CFG_READBACK_EN
//   defined   : rb_sdata is a registered copy of the MSB of shadow[rb_sel].
//               The PS can read a shadow back by clocking it through.
//   undefined : rb_sdata is tied low and rb_sel is ignored.
//
// Ports
//   clk          fabric clock
//   rst          asynchronous active-high reset
//   gpio_sdata   shared serial data (asynchronous to clk)
//   gpio_sclk    per-register serial clock (asynchronous to clk)
//   gpio_commit  commit strobe (asynchronous to clk)
//   err_clr      synchronous clear of all cfg_err bits
//   rb_sel       readback register index
//   cfg_q        active registers; register i at [i*REG_WIDTH +: REG_WIDTH]
//   cfg_updated  one-cycle pulse per register committed
//   cfg_err      sticky framing error per register
//   rb_sdata     readback serial data

module gpio_serial_cfg_bank #(
  parameter int                   NUM_REGS    = 8,
  parameter int                   REG_WIDTH   = 256,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                  SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gpio_sdata,
  input  logic [NUM_REGS-1:0]             gpio_sclk,
  input  logic                            gpio_commit,
  input  logic                            err_clr,
  input  logic [SEL_W-1:0]                rb_sel,
  output logic [NUM_REGS*REG_WIDTH-1:0]   cfg_q,
  output logic [NUM_REGS-1:0]             cfg_updated,
  output logic [NUM_REGS-1:0]             cfg_err,
  output logic                            rb_sdata
);

  localparam int                 CNT_W    = $clog2(REG_WIDTH + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(REG_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(REG_WIDTH + 1);

  logic [SYNC_STAGES-1:0] sdata_sync;
  logic [SYNC_STAGES-1:0] commit_sync;
  logic [NUM_REGS-1:0]    sclk_sync [SYNC_STAGES];
  logic [NUM_REGS-1:0]    sclk_prev;
  logic                   commit_prev;

  logic                   sdata_s;
  logic [NUM_REGS-1:0]    sclk_rise;
  logic                   commit_rise;

  // Synchroniser chains for every GPIO input plus one extra stage on the
  // clock and commit lines for edge detection. Data, serial clocks and commit
  // all pass through the same number of stages. The relative timing the PS
  // sets up on the pins therefore survives into the clk domain. Stage 0 is
  // the metastability-catching flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_sync  <= '0;
      commit_sync <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sclk_sync[s] <= '0;
      end
      sclk_prev   <= '0;
      commit_prev <= 1'b0;
    end else begin
      sdata_sync   <= {sdata_sync[SYNC_STAGES-2:0], gpio_sdata};
      commit_sync  <= {commit_sync[SYNC_STAGES-2:0], gpio_commit};
      sclk_sync[0] <= gpio_sclk;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sclk_sync[s] <= sclk_sync[s-1];
      end
      sclk_prev   <= sclk_sync[SYNC_STAGES-1];
      commit_prev <= commit_sync[SYNC_STAGES-1];
    end
  end

  // The edge flops reset to 0. A GPIO line that is already high after reset
  // is therefore seen as a rising edge.
  assign sdata_s     = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign commit_rise = commit_sync[SYNC_STAGES-1] & ~commit_prev;

`ifdef CFG_READBACK_EN
  logic [NUM_REGS-1:0] shadow_msb;
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [REG_WIDTH-1:0] shadow_r;
    logic [REG_WIDTH-1:0] active_r;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 upd_r;
    logic                 err_r;
    logic                 frame_ok;
    logic                 frame_bad;

    assign frame_ok  = (bit_cnt == CNT_FULL);
    assign frame_bad = (bit_cnt != '0) && !frame_ok;

    // One register slice.
    // Commit looks only at the pre-cycle count and shadow. A serial clock
    // edge in the same cycle still shifts, and its bit becomes the first bit
    // of the next frame, so the count restarts at 1. The count saturates one
    // past full. Overlong frames thus stay distinguishable from exact ones
    // however many extra bits arrive. A new framing error takes priority over
    // err_clr in the same cycle, so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_r <= RESET_VALUE;
        active_r <= RESET_VALUE;
        bit_cnt  <= '0;
        upd_r    <= 1'b0;
        err_r    <= 1'b0;
      end else begin
        upd_r <= commit_rise && frame_ok;

        if (commit_rise && frame_ok) begin
          active_r <= shadow_r;
        end

        if (commit_rise && frame_bad) begin
          err_r <= 1'b1;
        end else if (err_clr) begin
          err_r <= 1'b0;
        end

        if (sclk_rise[i]) begin
          shadow_r <= {shadow_r[REG_WIDTH-2:0], sdata_s};
          if (commit_rise) begin
            bit_cnt <= CNT_W'(1);
          end else if (bit_cnt != CNT_SAT) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else if (commit_rise) begin
          bit_cnt <= '0;
        end
      end
    end

    assign cfg_q[i*REG_WIDTH +: REG_WIDTH] = active_r;
    assign cfg_updated[i]                  = upd_r;
    assign cfg_err[i]                      = err_r;
`ifdef CFG_READBACK_EN
    assign shadow_msb[i]                   = shadow_r[REG_WIDTH-1];
`endif
  end

`ifdef CFG_READBACK_EN
  logic rb_next;

  // Readback mux. An index with no matching register falls through to 0.
  always_comb begin
    rb_next = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rb_sel == SEL_W'(i)) begin
        rb_next = shadow_msb[i];
      end
    end
  end

  // Register the selected shadow MSB so the PS sees a clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_sdata <= 1'b0;
    end else begin
      rb_sdata <= rb_next;
    end
  end
`else
  logic unused_rb_sel;

  assign unused_rb_sel = ^rb_sel;
  assign rb_sdata      = 1'b0;
`endif

endmodule
